// File: rtl/prbs_checker.sv
// prbs_checker: acquires and tracks a 10-bit pseudo-random word stream.
// State flow: SEED -> HUNT -> LOCK. Mismatching words are counted only
// while locked.
// Optional feature macro PRBS_CHK_BITERR_EN adds bit_err_count, which
// accumulates the number of differing bits per locked word.
module prbs_checker #(
  parameter int LOCK_MATCHES    = 8,
  parameter int LOSS_MISMATCHES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [9:0]       in_data,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_count
`endif
);

  typedef enum logic [1:0] {
    SEED = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_M = 8'(LOCK_MATCHES);
  localparam logic [7:0] LOSS_M = 8'(LOSS_MISMATCHES);

  // Generator step: shift left, feed back bits 9, 6 and 3.
  function automatic logic [9:0] next_word(input logic [9:0] w);
    return {w[8:0], w[9] ^ w[6] ^ w[3]};
  endfunction

  state_t           state_q, state_d;
  logic [9:0]       pred_q, pred_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic             word_nz;
  logic             word_match;
  logic [7:0]       match_inc;
  logic [7:0]       miss_inc;
  logic             count_err;

  assign word_nz    = (in_data != 10'd0);
  assign word_match = (in_data == pred_q);
  assign match_inc  = match_cnt_q + 8'd1;
  assign miss_inc   = miss_cnt_q + 8'd1;

  // Next-state logic for acquisition, tracking and the error counter.
  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
    count_err   = 1'b0;

    if (in_valid) begin
      case (state_q)
        SEED: begin
          // A zero word cannot seed the generator, so it is skipped.
          if (word_nz) begin
            pred_d      = next_word(in_data);
            match_cnt_d = 8'd0;
            state_d     = HUNT;
          end
        end
        HUNT: begin
          if (word_match) begin
            match_cnt_d = match_inc;
            pred_d      = next_word(in_data);
            if (match_inc == LOCK_M) begin
              state_d     = LOCK;
              match_cnt_d = 8'd0;
              miss_cnt_d  = 8'd0;
            end
          end else if (word_nz) begin
            pred_d      = next_word(in_data);
            match_cnt_d = 8'd0;
          end else begin
            state_d     = SEED;
            pred_d      = 10'd0;
            match_cnt_d = 8'd0;
          end
        end
        LOCK: begin
          // Free-run the predictor so corrupted input never disturbs it.
          pred_d = next_word(pred_q);
          if (!word_match) begin
            err_d      = 1'b1;
            count_err  = 1'b1;
            miss_cnt_d = miss_inc;
            if (miss_inc == LOSS_M) begin
              miss_cnt_d  = 8'd0;
              match_cnt_d = 8'd0;
              if (word_nz) begin
                state_d = HUNT;
                pred_d  = next_word(in_data);
              end else begin
                state_d = SEED;
                pred_d  = 10'd0;
              end
            end
          end else begin
            miss_cnt_d = 8'd0;
          end
        end
        default: begin
          state_d = SEED;
        end
      endcase
    end

    if (count_err && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
    // Clear takes priority over a coincident counted error.
    if (clr) begin
      err_count_d = '0;
    end

    locked_d = (state_d == LOCK);
  end

  // State and registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEED;
      pred_q      <= 10'd0;
      match_cnt_q <= 8'd0;
      miss_cnt_q  <= 8'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;

`ifdef PRBS_CHK_BITERR_EN
  logic [9:0]       bit_diff;
  logic [3:0]       bit_pop;
  logic [CNT_W+4:0] bit_sum;
  logic [CNT_W-1:0] bit_err_count_q, bit_err_count_d;

  assign bit_diff = in_data ^ pred_q;
  assign bit_sum  = {5'd0, bit_err_count_q} + {(CNT_W+1)'(0), bit_pop};

  // Population count of the differing bits in the current word.
  always_comb begin
    bit_pop = 4'd0;
    for (int i = 0; i < 10; i++) begin
      bit_pop = bit_pop + {3'd0, bit_diff[i]};
    end
  end

  // Accumulate bit errors while locked, clamping at all-ones.
  always_comb begin
    bit_err_count_d = bit_err_count_q;
    if (in_valid && (state_q == LOCK)) begin
      if (bit_sum > {5'd0, {CNT_W{1'b1}}}) begin
        bit_err_count_d = {CNT_W{1'b1}};
      end else begin
        bit_err_count_d = bit_sum[CNT_W-1:0];
      end
    end
    if (clr) begin
      bit_err_count_d = '0;
    end
  end

  // Bit error counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_err_count_q <= '0;
    end else begin
      bit_err_count_q <= bit_err_count_d;
    end
  end

  assign bit_err_count = bit_err_count_q;
`endif

endmodule
